// File: rtl/ip_unmask_seq.sv
// Sequential inner-product unmask: S = XOR_i gfmul(L_i, R_i) in GF(2^8) mod 0x11B,
// one shared multiplier stepped over the v share pairs, valid/ready on both sides.
module ip_unmask_seq #(
  parameter int unsigned v = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [v*8-1:0] L,
  input  logic [v*8-1:0] R,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [7:0]     S,
  output logic           busy
);

  localparam int unsigned IW = (v > 1) ? $clog2(v) : 1;
  localparam logic [IW-1:0] LAST = IW'(v - 1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t          state, state_nxt;
  logic [v*8-1:0]  L_q, R_q;
  logic [7:0]      acc, acc_nxt;
  logic [7:0]      mul_a, mul_b;
  logic [IW-1:0]   idx;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // Share selection by idx; a decoded mux keeps non-power-of-two v in range.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    for (int unsigned i = 0; i < v; i++) begin
      if (idx == IW'(i)) begin
        mul_a = L_q[i*8 +: 8];
        mul_b = R_q[i*8 +: 8];
      end
    end
  end

  assign acc_nxt = acc ^ gf_mul(mul_a, mul_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)      state_nxt = ACC;
      ACC:     if (idx == LAST)   state_nxt = DONE;
      DONE:    if (out_ready)     state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      L_q <= '0;
      R_q <= '0;
      acc <= '0;
      idx <= '0;
      S   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          L_q <= L;
          R_q <= R;
          acc <= '0;
          idx <= '0;
        end
        ACC: begin
          acc <= acc_nxt;
          if (idx == LAST) S <= acc_nxt;
          else             idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ip_unmask_seq.sv
// Directed bench for ip_unmask_seq: instances with v=8, v=2 and v=1 sharing clock and reset.
module tb_ip_unmask_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        iv8, ir8, ov8, or8, busy8;
  logic [63:0] l8, r8;
  logic [7:0]  s8;

  logic        iv2, ir2, ov2, or2, busy2;
  logic [15:0] l2, r2;
  logic [7:0]  s2;

  logic        iv1, ir1, ov1, or1, busy1;
  logic [7:0]  l1, r1;
  logic [7:0]  s1;

  ip_unmask_seq #(.v(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .L(l8), .R(r8),
    .out_valid(ov8), .out_ready(or8), .S(s8), .busy(busy8)
  );
  ip_unmask_seq #(.v(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .L(l2), .R(r2),
    .out_valid(ov2), .out_ready(or2), .S(s2), .busy(busy2)
  );
  ip_unmask_seq #(.v(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .L(l1), .R(r1),
    .out_valid(ov1), .out_ready(or1), .S(s1), .busy(busy1)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference multiply: repeated doubling (xtime) with conditional add.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] res, aa, bb;
    res = 8'h00; aa = a; bb = b;
    while (bb != 8'h00) begin
      if (bb[0]) res = res ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
      bb = bb >> 1;
    end
    return res;
  endfunction

  function automatic logic [7:0] ref_ip8(input logic [63:0] l, input logic [63:0] r);
    logic [7:0] s;
    s = 8'h00;
    for (int k = 0; k < 8; k++) s = s ^ ref_mul(l[k*8 +: 8], r[k*8 +: 8]);
    return s;
  endfunction

  task automatic wait_ov8(output int n);
    n = 0;
    while (!ov8 && n < 40) begin
      tick();
      n++;
    end
  endtask

  // One full v=8 transaction from IDLE: accept, latency, result, output handshake.
  task automatic txn8(input logic [63:0] l, input logic [63:0] r, input logic [7:0] exp,
                      input string tag);
    int n;
    l8 = l; r8 = r; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    l8 = '1; r8 = '1;
    wait_ov8(n);
    chk({tag, "_latency"}, n, 8);
    chk({tag, "_S"}, s8, exp);
    or8 = 1'b1;
    tick();
    or8 = 1'b0;
    chk({tag, "_in_ready_after"}, ir8, 1'b1);
  endtask

  initial begin
    int n;
    int unsigned prev;
    logic [63:0] sl, sr;
    logic [7:0]  sexp;

    rst_n = 1'b0;
    iv8 = 0; or8 = 0; l8 = '0; r8 = '0;
    iv2 = 0; or2 = 0; l2 = '0; r2 = '0;
    iv1 = 0; or1 = 0; l1 = '0; r1 = '0;
    #12;
    chk("rst_in_ready", ir8, 1'b1);
    chk("rst_out_valid", ov8, 1'b0);
    chk("rst_busy", busy8, 1'b0);
    chk("rst_S", s8, 8'h00);
    rst_n = 1'b1;
    tick();

    // v=2: 0x57*0x83 ^ 0x57*0x13 = 0xC1 ^ 0xFE
    l2 = {8'h57, 8'h57}; r2 = {8'h13, 8'h83}; iv2 = 1'b1;
    tick();
    iv2 = 1'b0;
    chk("v2_busy_acc", busy2, 1'b1);
    chk("v2_in_ready_acc", ir2, 1'b0);
    tick();
    chk("v2_ov_early", ov2, 1'b0);
    tick();
    chk("v2_ov_lat2", ov2, 1'b1);
    chk("v2_S", s2, 8'h3F);
    or2 = 1'b1;
    tick();
    or2 = 1'b0;
    chk("v2_ov_after", ov2, 1'b0);
    chk("v2_S_kept", s2, 8'h3F);

    // v=1: 0x02*0x80 = 0x1B, one ACC cycle
    l1 = 8'h02; r1 = 8'h80; iv1 = 1'b1;
    tick();
    iv1 = 1'b0;
    chk("v1_ov_early", ov1, 1'b0);
    tick();
    chk("v1_ov_lat1", ov1, 1'b1);
    chk("v1_S", s1, 8'h1B);
    or1 = 1'b1;
    tick();
    or1 = 1'b0;

    txn8({8{8'h01}}, 64'h0807060504030201, 8'h08, "ramp");
    txn8(64'h01, 64'h5A3C91E72D4F66AB, 8'hAB, "single");

    // Back-pressure: second pair (2*ramp -> 0x10) waits until the output handshake
    l8 = {8{8'h01}}; r8 = 64'h0807060504030201; iv8 = 1'b1;
    tick();
    l8 = {8{8'h02}};
    wait_ov8(n);
    chk("bp_latency", n, 8);
    for (int k = 0; k < 5; k++) begin
      chk("bp_S_hold", s8, 8'h08);
      chk("bp_in_ready_low", ir8, 1'b0);
      chk("bp_ov_hold", ov8, 1'b1);
      tick();
    end
    or8 = 1'b1;
    tick();
    or8 = 1'b0;
    chk("bp_in_ready_back", ir8, 1'b1);
    chk("bp_S_kept", s8, 8'h08);
    tick();
    iv8 = 1'b0;
    wait_ov8(n);
    chk("bp2_latency", n, 8);
    chk("bp2_S", s8, 8'h10);
    or8 = 1'b1;
    tick();
    or8 = 1'b0;

    // Reset at idx=3
    l8 = {8{8'h01}}; r8 = 64'h0807060504030201; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("rstacc_ov", ov8, 1'b0);
    chk("rstacc_S", s8, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rstacc_in_ready", ir8, 1'b1);
    for (int k = 0; k < 10; k++) tick();
    chk("rstacc_no_result", ov8, 1'b0);
    txn8({8{8'h01}}, 64'h0807060504030201, 8'h08, "post_rst");

    // Streaming with in_valid and out_ready held high
    or8 = 1'b1;
    prev = 0;
    sl = {$urandom, $urandom}; sr = {$urandom, $urandom};
    l8 = sl; r8 = sr; iv8 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      n = 0;
      while (!ir8 && n < 40) begin tick(); n++; end
      chk("stream_ready_wait", n < 40, 1'b1);
      sexp = ref_ip8(sl, sr);
      tick();
      sl = {$urandom, $urandom}; sr = {$urandom, $urandom};
      l8 = sl; r8 = sr;
      wait_ov8(n);
      chk("stream_latency", n, 8);
      chk("stream_S", s8, sexp);
      if (k > 0) chk("stream_period", cyc - prev, 10);
      prev = cyc;
    end
    iv8 = 1'b0;
    tick();
    or8 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
